triggerrec_event_capture: RTL and testbench
===========================================

# triggerrec_event_capture

Front-end capture stage of the trigger recorder. It synchronises the 16 GPIO inputs, detects masked pin changes, and stamps each change with a free-running 48-bit timestamp. It buffers the resulting 64-bit event words in a 2-entry queue and hands them to the recorder's trigger-match and event-FIFO logic over a valid/ready interface.

## Interface
Parameters:
- `IO_W`, 16: number of monitored pins.
- `TS_W`, 48: timestamp width. Event width is `IO_W + TS_W`, which must equal 64.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `io_in`  in  IO_W  raw asynchronous pin levels.
- `pin_mask`  in  IO_W  1 = pin participates in change detection.
- `run`  in  1  1 = timestamp counts and events are captured.
- `ts_load`  in  1  one-cycle strobe that loads `ts_load_val` into the timestamp.
- `ts_load_val`  in  TS_W  timestamp load value.
- `ev_valid`  out  1  head event available.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_data`  out  64  event word: {io_state[15:0], timestamp[47:0]}.
- `ts_now`  out  TS_W  current timestamp.
- `overflow`  out  1  sticky; set when an event is dropped. Cleared only by reset or `ovf_clr`.
- `ovf_clr`  in  1  clears `overflow` (and the drop counter, if present).
- `drop_count`  out  16  dropped-event count. Present only with `TRIGGERREC_DROP_COUNTER_EN`.

## Operation
- Sync chain: `io_s1 <= io_in`, `io_s2 <= io_s1`, `io_prev <= io_s2` every cycle, regardless of `run`.
- Change: `chg = ((io_s2 ^ io_prev) & pin_mask) != 0`.
- Capture: when `chg && run`, the event {io_s2, ts_now} is pushed into the buffer.
- Timestamp: `ts_load` has priority and sets `ts_now = ts_load_val`. Otherwise it increments by 1 when `run` = 1 and holds when `run` = 0. It wraps from 2^48-1 to 0 with no flag.
- Buffer: 2-entry FIFO holding count 0..2.
  - Push and pop in the same cycle are always accepted, including when the buffer is full.
  - A push while full with no pop is a drop: the event is discarded and `overflow` is set.
- Handshake:
  - Transfer occurs on a rising edge with `ev_valid && ev_ready`.
  - `ev_data` is stable while `ev_valid` is high and `ev_ready` is low.
  - `ev_valid` does not depend combinationally on `ev_ready`.
- `ovf_clr` coincident with a drop: the drop wins, so `overflow` stays 1 and the counter becomes 1.
- `run` falling: already-buffered events still drain.
- Mask changes take effect on the next comparison. No retroactive events are generated.

## Timing
- Reset values:
  - `ev_valid` = 0, `ev_data` = 0.
  - `ts_now` = 0, `overflow` = 0, `drop_count` = 0.
  - `io_s1`, `io_s2`, `io_prev` = 0, and the buffer is empty.
- Reset mid-operation discards buffered events. A pin held high through reset produces one event 2 cycles after reset deasserts (if masked in and `run` = 1).
- Latency: an `io_in` change sampled at edge N sets `ev_valid` = 1 after edge N+2. The event carries `ts_now` as it was in cycle N+1 (pre-increment).
- Throughput: one event per cycle sustained while `ev_ready` = 1.
- Back-to-back changes with `ev_ready` = 0: two events are held, the third and later are dropped.

## Configuration
- `TRIGGERREC_DROP_COUNTER_EN` defined:
  - 16-bit `drop_count` increments on each drop and saturates at 0xFFFF.
  - Cleared by `reset` or `ovf_clr`.
- Not defined: `drop_count` port and logic are absent. Only the sticky `overflow` flag remains.

## Structure
- `triggerrec_pkg` holds:
  - Constants `IO_W`, `TS_W`, `EV_W` = 64.
  - Field offsets `EV_IO_LSB` = 48 and `EV_TS_LSB` = 0.
  - Typedef `triggerrec_event_t` as a packed struct {io, ts}, shared with the trigger matcher and events FIFO.
- One sub-module, `triggerrec_evbuf`: 2-entry valid/ready buffer with push/full/drop signals. The sync chain, change detect and timestamp stay in the top module.

## Test plan
- Reset sequencing:
  - Reset for 5 cycles: all outputs 0, `ev_valid` = 0.
  - Release with `run` = 1: `ts_now` reads 10 after 10 edges.
- Single change: `pin_mask` = 0xFFFF, `ts_load` 0x000000001000, `io_in` 0 -> 0x7F01 at edge N.
  - `ev_valid` = 1 after edge N+2.
  - `ev_data` = 0x7F01_0000_0000_1000 + (N+1 - load edge).
  - Pop with `ev_ready` = 1: `ev_valid` returns to 0.
- Burst with stalled consumer:
  - `io_in` = 0x7F01, 0xBF20, 0x005A, 0 on consecutive cycles with `ev_ready` = 0.
  - Events 0x7F01 and 0xBF20 are held; 0x005A and 0 are dropped.
  - `overflow` = 1, `drop_count` = 2.
  - Then `ovf_clr`: both return to 0.
- Masking: `pin_mask` = 0x00FF, `io_in` toggles 0xFF00 -> no event. `io_in` 0x0001 -> event with io field 0x0001.
- Timestamp control:
  - `run` = 0: `ts_now` holds and pin changes produce no events.
  - `ts_load` 0xFFFF_FFFF_FFFF, then `run` = 1: `ts_now` wraps to 0 on the next edge.
- Simultaneous push/pop when full with `ev_ready` = 1 every cycle: no drop, `overflow` stays 0, and events arrive in order.

Source files
------------

// File: rtl/triggerrec_pkg.sv
// Shared definitions for the trigger recorder: pin/timestamp widths, event
// word layout and the event struct used by capture, matcher and event FIFO.
package triggerrec_pkg;

  localparam int IO_W      = 16;
  localparam int TS_W      = 48;
  localparam int EV_W      = 64;

  // Bit offsets of the fields inside a 64-bit event word.
  localparam int EV_IO_LSB = 48;
  localparam int EV_TS_LSB = 0;

  // Event word: pin levels in the upper bits, timestamp in the lower bits.
  typedef struct packed {
    logic [IO_W-1:0] io;
    logic [TS_W-1:0] ts;
  } triggerrec_event_t;

endpackage

// File: rtl/triggerrec_evbuf.sv
// Two-entry event buffer between the capture logic and the consumer.
// A push into a full buffer is accepted only if the head leaves in the same
// cycle; otherwise the event is discarded and 'drop' pulses for one cycle.
//
// Handshake: an event transfers on a rising clk edge where ev_valid and
// ev_ready are both 1. ev_valid is derived from registered occupancy only
// (never from ev_ready), and ev_data holds steady while ev_valid is 1 and
// ev_ready is 0.
module triggerrec_evbuf
  import triggerrec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  triggerrec_event_t push_data,
  output logic              drop,
  output logic              ev_valid,
  input  logic              ev_ready,
  output triggerrec_event_t ev_data
);

  triggerrec_event_t mem [2];
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              pop;
  logic              full;
  logic              push_ok;

  // Decide pop, drop and accepted push from occupancy and the handshake.
  always_comb begin
    pop     = (count != 2'd0) && ev_ready;
    full    = (count == 2'd2);
    drop    = push && full && !pop;
    push_ok = push && !drop;
  end

  assign ev_valid = (count != 2'd0);
  assign ev_data  = mem[rd_ptr];

  // Storage, pointers and occupancy; a full buffer with a pop reuses the
  // slot being emptied this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/triggerrec_event_capture.sv
// Trigger recorder capture front end: synchronises the GPIO pins, detects
// masked pin changes, stamps them with a free-running timestamp and queues
// them in a two-entry buffer toward the trigger matcher / event FIFO.
// Optional feature macro: TRIGGERREC_DROP_COUNTER_EN adds a saturating
// 16-bit drop_count output next to the sticky overflow flag.
module triggerrec_event_capture #(
  parameter int IO_W = triggerrec_pkg::IO_W,
  parameter int TS_W = triggerrec_pkg::TS_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IO_W-1:0]      io_in,
  input  logic [IO_W-1:0]      pin_mask,
  input  logic                 run,
  input  logic                 ts_load,
  input  logic [TS_W-1:0]      ts_load_val,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [IO_W+TS_W-1:0] ev_data,
  output logic [TS_W-1:0]      ts_now,
  input  logic                 ovf_clr,
  output logic                 overflow
`ifdef TRIGGERREC_DROP_COUNTER_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  logic [IO_W-1:0]                  io_s1;
  logic [IO_W-1:0]                  io_s2;
  logic [IO_W-1:0]                  io_prev;
  logic                             chg;
  logic                             push;
  logic                             drop;
  triggerrec_pkg::triggerrec_event_t push_ev;
  triggerrec_pkg::triggerrec_event_t head_ev;

  // Two-flop synchroniser plus one history stage; runs regardless of 'run'
  // so that resuming capture never sees a stale level difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_s1   <= '0;
      io_s2   <= '0;
      io_prev <= '0;
    end else begin
      io_s1   <= io_in;
      io_s2   <= io_s1;
      io_prev <= io_s2;
    end
  end

  // Masked change detect; the event carries this cycle's (pre-increment) time.
  always_comb begin
    chg     = (((io_s2 ^ io_prev) & pin_mask) != '0);
    push    = chg && run;
    push_ev = '{io: io_s2, ts: ts_now};
  end

  // Free-running timestamp: load wins, otherwise count while running; wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_now <= '0;
    end else if (ts_load) begin
      ts_now <= ts_load_val;
    end else if (run) begin
      ts_now <= ts_now + TS_W'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef TRIGGERREC_DROP_COUNTER_EN
  // Saturating drop counter; a clear coinciding with a drop leaves it at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= 16'd0;
    end else if (drop) begin
      if (ovf_clr) begin
        drop_count <= 16'd1;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (ovf_clr) begin
      drop_count <= 16'd0;
    end
  end
`endif

  triggerrec_evbuf u_evbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_ev),
    .drop      (drop),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (head_ev)
  );

  assign ev_data = head_ev;

endmodule

// File: tb/tb_triggerrec_event_capture.sv
// Bench for triggerrec_event_capture: a queue-based reference model checked
// every cycle, a table of burst/masking vectors, and hand-written sequences
// for reset, latency, timestamp control and full-buffer push/pop.
module tb_triggerrec_event_capture;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [15:0] io_in;
  logic [15:0] pin_mask;
  logic        run;
  logic        ts_load;
  logic [47:0] ts_load_val;
  logic        ev_valid;
  logic        ev_ready;
  logic [63:0] ev_data;
  logic [47:0] ts_now;
  logic        ovf_clr;
  logic        overflow;
`ifdef TRIGGERREC_DROP_COUNTER_EN
  logic [15:0] drop_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  triggerrec_event_capture dut (
    .clk         (clk),
    .reset       (reset),
    .io_in       (io_in),
    .pin_mask    (pin_mask),
    .run         (run),
    .ts_load     (ts_load),
    .ts_load_val (ts_load_val),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .ts_now      (ts_now),
    .ovf_clr     (ovf_clr),
    .overflow    (overflow)
`ifdef TRIGGERREC_DROP_COUNTER_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [15:0] m_s1, m_s2, m_prev;
  logic [47:0] m_ts;
  logic        m_ovf;
  logic [15:0] m_dc;
  logic        m_zero;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance model and DUT by one clock edge, then compare all outputs.
  task automatic tick();
    logic        pop;
    logic        push;
    logic        dropped;
    logic [63:0] ev;
    dropped = 1'b0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_ts = '0;
      exp_q.delete();
      m_ovf = 1'b0; m_dc = '0; m_zero = 1'b1;
    end else begin
      pop  = (exp_q.size() > 0) && ev_ready;
      push = (((m_s2 ^ m_prev) & pin_mask) != 16'h0) && run;
      ev   = {m_s2, m_ts};
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < 2) begin
          exp_q.push_back(ev);
          m_zero = 1'b0;
        end else begin
          dropped = 1'b1;
          m_ovf   = 1'b1;
          if (ovf_clr) m_dc = 16'd1;
          else if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
        end
      end
      if (!dropped && ovf_clr) begin
        m_ovf = 1'b0;
        m_dc  = '0;
      end
      if (ts_load) m_ts = ts_load_val;
      else if (run) m_ts = m_ts + 48'd1;
      m_prev = m_s2; m_s2 = m_s1; m_s1 = io_in;
    end
    @(posedge clk);
    #1;
    check("ev_valid", {63'd0, ev_valid}, {63'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) check("ev_data", ev_data, exp_q[0]);
    else if (m_zero) check("ev_data_zero", ev_data, 64'd0);
    check("ts_now", {16'd0, ts_now}, {16'd0, m_ts});
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
`ifdef TRIGGERREC_DROP_COUNTER_EN
    check("drop_count", {48'd0, drop_count}, {48'd0, m_dc});
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] io;
    logic [15:0] mask;
    logic        ready;
    logic        clr;
    logic        exp_valid;
    logic [15:0] exp_io;
    logic        exp_ovf;
    logic [15:0] exp_dc;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [15:0] io, input logic [15:0] mask,
                              input logic ready, input logic clr, input logic ev,
                              input logic [15:0] eio, input logic eovf,
                              input logic [15:0] edc);
    vec_t v;
    v.io = io; v.mask = mask; v.ready = ready; v.clr = clr;
    v.exp_valid = ev; v.exp_io = eio; v.exp_ovf = eovf; v.exp_dc = edc;
    return v;
  endfunction

  // ---------------- driver / stimulus ----------------
  initial begin
    logic [47:0] t0;
    reset = 1'b1; io_in = '0; pin_mask = 16'hFFFF; run = 1'b0;
    ts_load = 1'b0; ts_load_val = '0; ev_ready = 1'b0; ovf_clr = 1'b0;

    // Burst with stalled consumer, then clear, drain and masking.
    vecs[0]  = mk(16'h7F01, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(16'hBF20, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 0);
    vecs[2]  = mk(16'h005A, 16'hFFFF, 0, 0, 1, 16'h7F01, 0, 0);
    vecs[3]  = mk(16'h0000, 16'hFFFF, 0, 0, 1, 16'h7F01, 0, 0);
    vecs[4]  = mk(16'h0000, 16'hFFFF, 0, 0, 1, 16'h7F01, 1, 1);
    vecs[5]  = mk(16'h0000, 16'hFFFF, 0, 0, 1, 16'h7F01, 1, 2);
    vecs[6]  = mk(16'h0000, 16'hFFFF, 0, 0, 1, 16'h7F01, 1, 2);
    vecs[7]  = mk(16'h0000, 16'hFFFF, 0, 1, 1, 16'h7F01, 0, 0);
    vecs[8]  = mk(16'h0000, 16'hFFFF, 1, 0, 1, 16'hBF20, 0, 0);
    vecs[9]  = mk(16'h0000, 16'hFFFF, 1, 0, 0, 16'h0000, 0, 0);
    vecs[10] = mk(16'hFF00, 16'h00FF, 1, 0, 0, 16'h0000, 0, 0);
    vecs[11] = mk(16'hFF00, 16'h00FF, 1, 0, 0, 16'h0000, 0, 0);
    vecs[12] = mk(16'hFF00, 16'h00FF, 1, 0, 0, 16'h0000, 0, 0);
    vecs[13] = mk(16'h0001, 16'h00FF, 1, 0, 0, 16'h0000, 0, 0);
    vecs[14] = mk(16'h0001, 16'h00FF, 1, 0, 0, 16'h0000, 0, 0);
    vecs[15] = mk(16'h0001, 16'h00FF, 0, 0, 1, 16'h0001, 0, 0);
    vecs[16] = mk(16'h0001, 16'h00FF, 1, 0, 0, 16'h0000, 0, 0);

    // Reset sequencing: 5 cycles of reset, outputs all zero.
    for (int i = 0; i < 5; i++) tick();
    check("rst_valid", {63'd0, ev_valid}, 64'd0);
    check("rst_data", ev_data, 64'd0);
    check("rst_ts", {16'd0, ts_now}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);

    // Release with run=1: timestamp reads 10 after 10 edges.
    reset = 1'b0; run = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("ts_after_10", {16'd0, ts_now}, 64'd10);

    // Single change with loaded timestamp; event stamped with load+2.
    ts_load = 1'b1; ts_load_val = 48'h0000_0000_1000;
    tick();
    ts_load = 1'b0; io_in = 16'h7F01;
    tick();
    check("single_lat_n", {63'd0, ev_valid}, 64'd0);
    tick();
    check("single_lat_n1", {63'd0, ev_valid}, 64'd0);
    tick();
    check("single_valid", {63'd0, ev_valid}, 64'd1);
    check("single_data", ev_data, 64'h7F01_0000_0000_1002);
    ev_ready = 1'b1;
    tick();
    check("single_pop", {63'd0, ev_valid}, 64'd0);
    io_in = 16'h0000;
    for (int i = 0; i < 5; i++) tick();

    // Table-driven burst / clear / masking vectors.
    ev_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      io_in = vecs[i].io; pin_mask = vecs[i].mask;
      ev_ready = vecs[i].ready; ovf_clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_valid", i), {63'd0, ev_valid}, {63'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_io", i), {48'd0, ev_data[63:48]}, {48'd0, vecs[i].exp_io});
      check($sformatf("vec%0d_ovf", i), {63'd0, overflow}, {63'd0, vecs[i].exp_ovf});
`ifdef TRIGGERREC_DROP_COUNTER_EN
      check($sformatf("vec%0d_dc", i), {48'd0, drop_count}, {48'd0, vecs[i].exp_dc});
`endif
    end
    ovf_clr = 1'b0; pin_mask = 16'hFFFF; io_in = 16'h0000; ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // run=0: timestamp holds and pin changes are ignored.
    run = 1'b0; t0 = m_ts; io_in = 16'h1234;
    for (int i = 0; i < 5; i++) tick();
    check("run0_ts_hold", {16'd0, ts_now}, {16'd0, t0});
    check("run0_no_event", {63'd0, ev_valid}, 64'd0);
    io_in = 16'h0000;
    for (int i = 0; i < 3; i++) tick();

    // Timestamp wrap.
    ts_load = 1'b1; ts_load_val = 48'hFFFF_FFFF_FFFF;
    tick();
    ts_load = 1'b0;
    check("ts_loaded_max", {16'd0, ts_now}, 64'h0000_FFFF_FFFF_FFFF);
    run = 1'b1;
    tick();
    check("ts_wrap", {16'd0, ts_now}, 64'd0);

    // Fill the buffer, then push and pop every cycle while full.
    ev_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      io_in = 16'(i * 16'h1111);
      tick();
    end
    check("full_before_stream", {63'd0, ev_valid}, 64'd1);
    ev_ready = 1'b1;
    for (int i = 5; i <= 12; i++) begin
      io_in = 16'(i * 16'h1111);
      tick();
    end
    check("full_stream_no_ovf", {63'd0, overflow}, 64'd0);
    for (int i = 0; i < 5; i++) tick();

    // Reset mid-operation with a pin held high through reset.
    ev_ready = 1'b0; io_in = 16'h00F0;
    for (int i = 0; i < 4; i++) tick();
    io_in = 16'hFFFF; reset = 1'b1;
    tick(); tick();
    check("midrst_empty", {63'd0, ev_valid}, 64'd0);
    reset = 1'b0;
    tick(); tick();
    check("held_pin_lat2", {63'd0, ev_valid}, 64'd0);
    tick();
    check("held_pin_valid", {63'd0, ev_valid}, 64'd1);
    check("held_pin_io", {48'd0, ev_data[63:48]}, 64'h0000_0000_0000_FFFF);
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) io_in = 16'($urandom);
      if ($urandom_range(0, 30) == 0) pin_mask = 16'($urandom);
      ev_ready    = ($urandom_range(0, 2) != 0);
      run         = ($urandom_range(0, 9) != 0);
      ovf_clr     = ($urandom_range(0, 19) == 0);
      ts_load     = ($urandom_range(0, 49) == 0);
      ts_load_val = {16'($urandom), 32'($urandom)};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
